// File: rtl/regfile_pkg.sv
// Shared defaults and word/index types for the CPU register file.
package regfile_pkg;

    localparam int unsigned REG_DATA_W   = 64;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned REG_ZERO_IDX = 31;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_decoded_if.sv
// Register-file access bundle: one write port plus NUM_RD packed read ports.
interface regfile_decoded_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_DATA_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned NUM_RD = 2
);

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/onehot_decoder.sv
// Generic binary-to-one-hot decoder with enable; out is all zeros when en is low.
module onehot_decoder #(
    parameter int unsigned IN_W = 5
) (
    input  logic [IN_W-1:0]      in,
    input  logic                 en,
    output logic [2**IN_W-1:0]   out
);

    localparam int unsigned OUT_W = 2**IN_W;

    assign out = {{(OUT_W-1){1'b0}}, en} << in;

endmodule

// File: rtl/regfile_decoded.sv
// Register file: decoded synchronous write, NUM_RD combinational reads, hardwired zero register.
// Define WRITE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_decoded
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = REG_DATA_W,
    parameter int unsigned ADDR_W   = REG_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_IDX = REG_ZERO_IDX
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_decoded_if.slave      bus
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_IDX);

    logic [DEPTH-1:0]         wr_sel;
    logic                     wr_allow;
    logic [DATA_W-1:0]        regs_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_data_flat;

    // The zero register is excluded at the decoder so it never gets a load enable.
    assign wr_allow = bus.wr_en && (bus.wr_addr != ZeroAddr);

    onehot_decoder #(
        .IN_W (ADDR_W)
    ) u_wr_dec (
        .in  (bus.wr_addr),
        .en  (wr_allow),
        .out (wr_sel)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (wr_sel[i]) begin
                    regs_q[i] <= bus.wr_data;
                end
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        logic [ADDR_W-1:0] rd_idx;
        logic [DATA_W-1:0] rd_word;

        assign rd_idx = bus.rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd_word = regs_q[rd_idx];
            if (rd_idx == ZeroAddr) begin
                rd_word = '0;
            end
`ifdef WRITE_BYPASS_EN
            if (reset_n && wr_allow && (bus.wr_addr == rd_idx)) begin
                rd_word = bus.wr_data;
            end
`endif
        end

        assign rd_data_flat[k*DATA_W +: DATA_W] = rd_word;
    end

    assign bus.rd_data = rd_data_flat;

endmodule

// File: tb/tb_regfile_decoded.sv
// Randomised self-checking bench for regfile_decoded against an array-based reference model.
module tb_regfile_decoded;
    import regfile_pkg::*;

    localparam int unsigned NUM_RD = 2;
    localparam int unsigned DEPTH  = 2**REG_ADDR_W;

    logic clk;
    logic reset_n;

    regfile_decoded_if #(
        .DATA_W (REG_DATA_W),
        .ADDR_W (REG_ADDR_W),
        .NUM_RD (NUM_RD)
    ) bus ();

    regfile_decoded #(
        .DATA_W   (REG_DATA_W),
        .ADDR_W   (REG_ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_IDX (REG_ZERO_IDX)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    reg_data_t model [DEPTH];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input reg_data_t obs, input reg_data_t exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // What a read of address a should return given current inputs and model state.
    function automatic reg_data_t expect_rd(input reg_addr_t a);
        if (!reset_n) return '0;
        if (int'(a) == int'(REG_ZERO_IDX)) return '0;
`ifdef WRITE_BYPASS_EN
        if (bus.wr_en && bus.wr_addr == a) return bus.wr_data;
`endif
        return model[a];
    endfunction

    // Drive both read addresses, let the comb path settle, compare both ports.
    task automatic read_check(input string tag, input reg_addr_t a0, input reg_addr_t a1);
        bus.rd_addr = {a1, a0};
        #1;
        check_eq({tag, "_p0"}, bus.rd_data[0 +: REG_DATA_W], expect_rd(a0));
        check_eq({tag, "_p1"}, bus.rd_data[REG_DATA_W +: REG_DATA_W], expect_rd(a1));
    endtask

    // Advance one clock: apply the architectural write rule at the edge, return at negedge.
    task automatic step();
        logic      en;
        reg_addr_t a;
        reg_data_t d;
        en = bus.wr_en;
        a  = bus.wr_addr;
        d  = bus.wr_data;
        @(posedge clk);
        if (reset_n && en && int'(a) != int'(REG_ZERO_IDX)) model[a] = d;
        @(negedge clk);
    endtask

    task automatic write(input reg_addr_t a, input reg_data_t d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 64'hDEAD;
        bus.rd_addr = '0;
        model_clear();

        // Reset holds everything at zero even with a write pending.
        @(negedge clk);
        step();
        step();
        read_check("rst_hold", 5'd3, 5'd0);
        read_check("rst_hold_b", 5'd12, 5'd30);
        bus.wr_en = 1'b0;
        reset_n   = 1'b1;
        step();
        read_check("rst_rel", 5'd3, 5'd3);

        // Sweep all registers, including a write aimed at the zero register.
        for (int i = 0; i < int'(DEPTH); i++) begin
            write(reg_addr_t'(i), reg_data_t'(i) * 64'h0101);
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            read_check("sweep", reg_addr_t'(i), reg_addr_t'(DEPTH - 1 - i));
        end

        // Zero register ignores an all-ones write; others untouched.
        write(reg_addr_t'(REG_ZERO_IDX), 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < int'(DEPTH); i++) begin
            read_check("zero_reg", reg_addr_t'(REG_ZERO_IDX), reg_addr_t'(i));
        end

        // Disabled write leaves the target alone.
        bus.wr_en   = 1'b0;
        bus.wr_addr = 5'd5;
        bus.wr_data = 64'h1234;
        repeat (3) step();
        read_check("wr_en0", 5'd5, 5'd5);

        // Same-cycle read of the address being written.
        write(5'd7, 64'hA);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd7;
        bus.wr_data = 64'hB;
        read_check("same_cyc", 5'd7, 5'd6);
        step();
        bus.wr_en = 1'b0;
        read_check("same_next", 5'd7, 5'd7);

        // Random traffic, with read addresses biased toward the write address.
        for (int n = 0; n < 300; n++) begin
            reg_addr_t r0, r1;
            bus.wr_en   = ($urandom_range(0, 3) != 0);
            bus.wr_addr = reg_addr_t'($urandom);
            bus.wr_data = {$urandom, $urandom};
            r0 = ($urandom_range(0, 3) == 0) ? bus.wr_addr : reg_addr_t'($urandom);
            r1 = ($urandom_range(0, 3) == 0) ? bus.wr_addr : reg_addr_t'($urandom);
            read_check("rand", r0, r1);
            step();
        end
        bus.wr_en = 1'b0;

        // Asynchronous reset between edges clears storage immediately.
        write(5'd10, 64'h55);
        read_check("pre_rst", 5'd10, 5'd10);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd10;
        bus.wr_data = 64'h77;
        #2;
        reset_n = 1'b0;
        model_clear();
        read_check("async_rst", 5'd10, 5'd7);
        step();
        read_check("rst_vs_wr", 5'd10, 5'd10);
        bus.wr_en = 1'b0;
        reset_n   = 1'b1;
        step();
        read_check("post_rst", 5'd10, 5'd7);
        write(5'd10, 64'h99);
        read_check("rewrite", 5'd10, 5'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_decoded.md
Name: regfile_decoded

Overview:
Parametrised register file for the pipelined CPU, built around a generalised one-hot write-address decoder with enable. It provides one synchronous write port and two asynchronous read ports, with a hardwired zero register. Word width, address width and read-port count are parametrised. It replaces fixed 5-to-32 decode plus discrete flops in the decode/writeback stages.

Parameters:
DATA_W, 64, width of each register in bits
ADDR_W, 5, address width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports (1..4)
ZERO_IDX, 31, index of hardwired-zero register; writes ignored, reads return 0

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
wr_en  input  1  write enable, sampled at rising clk
wr_addr  input  ADDR_W  write register index
wr_data  input  DATA_W  write data
rd_addr  input  NUM_RD*ADDR_W  packed read indices; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]

Interface note: one clock (clk); reset_n is asynchronous and active-low.

Behaviour:
- Storage: 2**ADDR_W registers of DATA_W bits each.
- Reset: reset_n low clears every register to 0 immediately, independent of clk. While reset_n is low, rd_data is all zeros and writes are ignored. Deassertion is not synchronised inside the block; the reset source guarantees clean release.
- Write decode: wr_addr is decoded to a 2**ADDR_W one-hot vector, gated by wr_en. At a rising clk edge, only the selected register loads wr_data. All other registers hold.
  - wr_en=0: no register changes.
  - wr_addr==ZERO_IDX: the decoded enable is forced low and no register changes.
- Write latency: a write becomes visible to reads one cycle after the clock edge (write-then-read ordering) unless WRITE_BYPASS_EN is defined.
- Read ports: combinational, zero-cycle latency; rd_data[k] = reg[rd_addr[k]].
  - If rd_addr[k]==ZERO_IDX, rd_data[k] = 0 regardless of stored contents.
  - All read ports are independent. The same address on several ports returns the same value.
- Simultaneous events:
  - Read of the address being written in the same cycle returns the old value (no bypass build).
  - Reset asserted in the same cycle as a write: reset wins and the register reads 0.
- Addresses cover the full decode range, so no out-of-range case exists.
- X-safety: X on wr_en or wr_addr while reset_n=1 is a bench error; the design need not mask it.

Optional Feature:
WRITE_BYPASS_EN
- Defined: for each read port k, if wr_en=1, wr_addr==rd_addr[k] and wr_addr!=ZERO_IDX, then rd_data[k]=wr_data combinationally in the same cycle (write-through forwarding for the writeback stage).
- Undefined: no bypass; reads return the stored value, and same-cycle writes appear after the edge.
- Bypass is also suppressed while reset_n=0.

Decomposition:
- Package regfile_pkg contains:
  - localparam defaults REG_DATA_W=64, REG_ADDR_W=5, REG_ZERO_IDX=31.
  - typedefs reg_addr_t = logic [REG_ADDR_W-1:0] and reg_data_t = logic [REG_DATA_W-1:0].
- One natural sub-module: onehot_decoder #(IN_W), with ports in [IN_W-1:0], en, out [2**IN_W-1:0]. out = en ? (1<<in) : 0. It is the generalised successor of the fixed 2-to-4 / 3-to-8 / 5-to-32 decoder tree, written as a single generate/shift rather than a hierarchy.
- Read muxes stay inline, one generate loop per port.

Test Plan:
1. Reset: hold reset_n=0, clk running, wr_en=1, wr_addr=3, wr_data=64'hDEAD -> all rd_data=0; after release, read addr 3 -> 0.
2. Write/read sweep: for i=0..30, write data i*64'h0101 to addr i, then read every addr on both ports -> matching value; addr 31 -> 0.
3. Zero register: write 64'hFFFF_FFFF_FFFF_FFFF to ZERO_IDX=31, then read 31 -> 0; registers 0..30 unchanged.
4. wr_en=0: wr_addr=5, wr_data=64'h1234 for 3 cycles -> reg5 keeps its prior value.
5. Same-cycle read/write on addr 7: old=64'hA, new=64'hB. Without WRITE_BYPASS_EN: rd=A in that cycle, B next cycle. With the macro: rd=B in the same cycle.
6. Mid-operation reset: write addr 10=64'h55, then assert reset_n=0 between clk edges -> rd_data for addr 10 drops to 0 immediately (async); after release it stays 0 until rewritten.
